processor_param: RTL and testbench

Parametrised multicycle register-transfer processor: the next generation of our single-bus datapath with register file, A/R latches, operand mux, ALU and step-sequenced control. It generalises data width and register count, adds a valid/ready instruction handshake, a completion pulse, status flags and illegal-opcode detection. It sits between the instruction source (test ROM or host FSM) and the bus observer, driving the internal bus value out for monitoring.

---
 rtl/processor_param.sv | 154 +++++++++++++++
 tb/tb_processor_param.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/processor_param.sv
// Parametrised multicycle register-transfer processor: register file, A/R latches,
// ALU and step-sequenced control behind a valid/ready instruction handshake.
//
// state  | meaning
// S_IDLE | waiting for an instruction (iin_ready high)
// S_T1   | MV/MVI writeback, or ALU: A <- rx
// S_T2   | ALU: R <- ALU(A, ry)
// S_T3   | ALU: rx <- R, flags updated
module processor_param #(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 3
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [DATA_W-1:0] iin,
  input  logic              iin_valid,
  output logic              iin_ready,
  output logic [DATA_W-1:0] bus,
  output logic              done,
  output logic [3:0]        flags,
  output logic              illegal
);
  localparam int NREGS = 2**REG_ADDR_W;
  localparam int IMM_W = DATA_W - 4 - REG_ADDR_W;

  localparam logic [3:0] OP_MV  = 4'd0;
  localparam logic [3:0] OP_MVI = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_SLT = 4'd7;
  localparam logic [3:0] OP_NOP = 4'd15;

  typedef enum logic [1:0] {S_IDLE, S_T1, S_T2, S_T3} state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0]     regs [NREGS];
  logic [DATA_W-1:0]     ir, a_q, r_q;
  logic [3:0]            flags_q;
  logic [3:0]            op;
  logic [REG_ADDR_W-1:0] rx, ry;
  logic [DATA_W-1:0]     imm_sx, rx_val, ry_val;
  logic                  is_alu, is_illegal, accept;
  logic [DATA_W:0]       sum, diff;
  logic [DATA_W-1:0]     alu_res;
  logic                  alu_c, alu_v;

  assign op     = ir[DATA_W-1 -: 4];
  assign rx     = ir[DATA_W-5 -: REG_ADDR_W];
  assign ry     = ir[DATA_W-5-REG_ADDR_W -: REG_ADDR_W];
  assign imm_sx = {{(DATA_W-IMM_W){ir[IMM_W-1]}}, ir[IMM_W-1:0]};
  assign rx_val = regs[rx];
  assign ry_val = regs[ry];

  assign is_alu     = (op >= OP_ADD) && (op <= OP_SLT);
  assign is_illegal = op[3] && (op != OP_NOP);
  assign iin_ready  = (state == S_IDLE) && !resetn;
  assign accept     = iin_valid && iin_ready;
  assign flags      = flags_q;

  // Carry/overflow are re-derived at T3 from A and ry, which are still intact then.
  always_comb begin
    sum     = {1'b0, a_q} + {1'b0, ry_val};
    diff    = {1'b0, a_q} - {1'b0, ry_val};
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = sum[DATA_W-1:0];
        alu_c   = sum[DATA_W];
        alu_v   = (a_q[DATA_W-1] == ry_val[DATA_W-1]) && (sum[DATA_W-1] != a_q[DATA_W-1]);
      end
      OP_SUB: begin
        alu_res = diff[DATA_W-1:0];
        alu_c   = !diff[DATA_W];
        alu_v   = (a_q[DATA_W-1] != ry_val[DATA_W-1]) && (diff[DATA_W-1] != a_q[DATA_W-1]);
      end
      OP_AND:  alu_res = a_q & ry_val;
      OP_OR:   alu_res = a_q | ry_val;
      OP_XOR:  alu_res = a_q ^ ry_val;
      OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(ry_val))};
      default: ;
    endcase
  end

  always_comb begin
    bus = '0;
    case (state)
      S_T1: begin
        if (op == OP_MV)       bus = ry_val;
        else if (op == OP_MVI) bus = imm_sx;
        else if (is_alu)       bus = rx_val;
      end
      S_T2:    bus = ry_val;
      S_T3:    bus = r_q;
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_T1;
      S_T1:    state_nxt = is_alu ? S_T2 : S_IDLE;
      S_T2:    state_nxt = S_T3;
      S_T3:    state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge resetn) begin
    if (resetn) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clock or posedge resetn) begin
    if (resetn) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      ir      <= '0;
      a_q     <= '0;
      r_q     <= '0;
      flags_q <= '0;
      done    <= 1'b0;
      illegal <= 1'b0;
    end else begin
      done    <= 1'b0;
      illegal <= 1'b0;
      case (state)
        S_IDLE: if (accept) ir <= iin;
        S_T1: begin
          if (op == OP_MV)       regs[rx] <= ry_val;
          else if (op == OP_MVI) regs[rx] <= imm_sx;
          if (is_alu) begin
            a_q <= rx_val;
          end else begin
            done    <= 1'b1;
            illegal <= is_illegal;
          end
        end
        S_T2: r_q <= alu_res;
        S_T3: begin
          regs[rx] <= r_q;
          flags_q  <= {(r_q == '0), r_q[DATA_W-1], alu_c, alu_v};
          done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_processor_param.sv
// Directed bench for processor_param: a 16-bit instance driven from a vector table
// plus handshake/reset sequences, and a 32-bit/16-register instance.
module tb_processor_param;
  logic clock  = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  logic [15:0] iin, bus;
  logic        iin_valid, iin_ready, done, illegal;
  logic [3:0]  flags;

  logic [31:0] iin32, bus32;
  logic        iin_valid32, iin_ready32, done32, illegal32;
  logic [3:0]  flags32;

  processor_param #(.DATA_W(16), .REG_ADDR_W(3)) dut (
    .clock(clock), .resetn(resetn), .iin(iin), .iin_valid(iin_valid),
    .iin_ready(iin_ready), .bus(bus), .done(done), .flags(flags), .illegal(illegal)
  );

  processor_param #(.DATA_W(32), .REG_ADDR_W(4)) dut32 (
    .clock(clock), .resetn(resetn), .iin(iin32), .iin_valid(iin_valid32),
    .iin_ready(iin_ready32), .bus(bus32), .done(done32), .flags(flags32), .illegal(illegal32)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [15:0] ins;
    logic [1:0]  steps;
    logic [15:0] b0, b1, b2;
    logic [3:0]  fl;
    logic        ill;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [15:0] enc(input logic [3:0] op, input logic [2:0] rx, input logic [2:0] ry);
    return {op, rx, ry, 6'b0};
  endfunction

  function automatic logic [15:0] mvi(input logic [2:0] rx, input logic [8:0] imm);
    return {4'd1, rx, imm};
  endfunction

  function automatic vec_t mk(input logic [15:0] ins, input logic [1:0] steps, input logic [15:0] b0,
                              input logic [15:0] b1, input logic [15:0] b2, input logic [3:0] fl,
                              input logic ill);
    vec_t v;
    v.ins = ins; v.steps = steps; v.b0 = b0; v.b1 = b1; v.b2 = b2; v.fl = fl; v.ill = ill;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Call at a negedge; returns 1ns after the accept edge (FSM in T1).
  task automatic send(input logic [15:0] ins, input logic keep_valid);
    int n = 0;
    iin = ins;
    iin_valid = 1'b1;
    while (!iin_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("send ready", {31'b0, iin_ready}, 32'd1);
    @(posedge clock);
    #1;
    if (!keep_valid) iin_valid = 1'b0;
  endtask

  task automatic run32(input logic [31:0] ins, input int steps, input logic [31:0] b0,
                       input logic [31:0] b1, input logic [31:0] b2, input logic [3:0] fl);
    int n = 0;
    iin32 = ins;
    iin_valid32 = 1'b1;
    while (!iin_ready32 && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("w32 ready", {31'b0, iin_ready32}, 32'd1);
    @(posedge clock);
    #1;
    iin_valid32 = 1'b0;
    for (int s = 0; s < steps; s++) begin
      @(negedge clock);
      check($sformatf("w32 %0h bus t%0d", ins, s + 1), bus32, (s == 0) ? b0 : (s == 1) ? b1 : b2);
    end
    @(negedge clock);
    check($sformatf("w32 %0h done", ins), {31'b0, done32}, 32'd1);
    check($sformatf("w32 %0h flags", ins), {28'b0, flags32}, {28'b0, fl});
  endtask

  initial begin
    vec_t v;
    iin = '0; iin_valid = 1'b0;
    iin32 = '0; iin_valid32 = 1'b0;

    vecs.push_back(mk(enc(4'd0, 3'd1, 3'd0), 2'd1, 16'h0000, 16'h0, 16'h0, 4'b0000, 1'b0));
    vecs.push_back(mk(mvi(3'd0, 9'h005),     2'd1, 16'h0005, 16'h0, 16'h0, 4'b0000, 1'b0));
    vecs.push_back(mk(enc(4'd0, 3'd3, 3'd0), 2'd1, 16'h0005, 16'h0, 16'h0, 4'b0000, 1'b0));
    vecs.push_back(mk(enc(4'd2, 3'd3, 3'd3), 2'd3, 16'h0005, 16'h0005, 16'h000A, 4'b0000, 1'b0));
    vecs.push_back(mk(enc(4'd0, 3'd3, 3'd3), 2'd1, 16'h000A, 16'h0, 16'h0, 4'b0000, 1'b0));
    vecs.push_back(mk(mvi(3'd1, 9'h0FF),     2'd1, 16'h00FF, 16'h0, 16'h0, 4'b0000, 1'b0));
    vecs.push_back(mk(mvi(3'd2, 9'h1FF),     2'd1, 16'hFFFF, 16'h0, 16'h0, 4'b0000, 1'b0));
    vecs.push_back(mk(enc(4'd2, 3'd1, 3'd2), 2'd3, 16'h00FF, 16'hFFFF, 16'h00FE, 4'b0010, 1'b0));
    vecs.push_back(mk(mvi(3'd4, 9'h100),     2'd1, 16'hFF00, 16'h0, 16'h0, 4'b0010, 1'b0));
    vecs.push_back(mk(enc(4'd2, 3'd4, 3'd4), 2'd3, 16'hFF00, 16'hFF00, 16'hFE00, 4'b0110, 1'b0));
    vecs.push_back(mk(enc(4'd2, 3'd4, 3'd4), 2'd3, 16'hFE00, 16'hFE00, 16'hFC00, 4'b0110, 1'b0));
    vecs.push_back(mk(enc(4'd2, 3'd4, 3'd4), 2'd3, 16'hFC00, 16'hFC00, 16'hF800, 4'b0110, 1'b0));
    vecs.push_back(mk(enc(4'd2, 3'd4, 3'd4), 2'd3, 16'hF800, 16'hF800, 16'hF000, 4'b0110, 1'b0));
    vecs.push_back(mk(enc(4'd2, 3'd4, 3'd4), 2'd3, 16'hF000, 16'hF000, 16'hE000, 4'b0110, 1'b0));
    vecs.push_back(mk(enc(4'd2, 3'd4, 3'd4), 2'd3, 16'hE000, 16'hE000, 16'hC000, 4'b0110, 1'b0));
    vecs.push_back(mk(enc(4'd2, 3'd4, 3'd4), 2'd3, 16'hC000, 16'hC000, 16'h8000, 4'b0110, 1'b0));
    vecs.push_back(mk(mvi(3'd5, 9'h001),     2'd1, 16'h0001, 16'h0, 16'h0, 4'b0110, 1'b0));
    vecs.push_back(mk(enc(4'd3, 3'd4, 3'd5), 2'd3, 16'h8000, 16'h0001, 16'h7FFF, 4'b0011, 1'b0));
    vecs.push_back(mk(enc(4'd7, 3'd5, 3'd4), 2'd3, 16'h0001, 16'h7FFF, 16'h0001, 4'b0000, 1'b0));
    vecs.push_back(mk(enc(4'd7, 3'd4, 3'd5), 2'd3, 16'h7FFF, 16'h0001, 16'h0000, 4'b1000, 1'b0));
    vecs.push_back(mk(enc(4'd5, 3'd3, 3'd0), 2'd3, 16'h000A, 16'h0005, 16'h000F, 4'b0000, 1'b0));
    vecs.push_back(mk(enc(4'd6, 3'd3, 3'd0), 2'd3, 16'h000F, 16'h0005, 16'h000A, 4'b0000, 1'b0));
    vecs.push_back(mk(enc(4'd4, 3'd3, 3'd0), 2'd3, 16'h000A, 16'h0005, 16'h0000, 4'b1000, 1'b0));
    vecs.push_back(mk(enc(4'd9, 3'd3, 3'd0), 2'd1, 16'h0000, 16'h0, 16'h0, 4'b1000, 1'b1));
    vecs.push_back(mk(enc(4'd15, 3'd0, 3'd0), 2'd1, 16'h0000, 16'h0, 16'h0, 4'b1000, 1'b0));
    vecs.push_back(mk(enc(4'd0, 3'd3, 3'd3), 2'd1, 16'h0000, 16'h0, 16'h0, 4'b1000, 1'b0));
    vecs.push_back(mk(enc(4'd0, 3'd0, 3'd0), 2'd1, 16'h0005, 16'h0, 16'h0, 4'b1000, 1'b0));
    vecs.push_back(mk(enc(4'd14, 3'd1, 3'd1), 2'd1, 16'h0000, 16'h0, 16'h0, 4'b1000, 1'b1));
    vecs.push_back(mk(enc(4'd0, 3'd1, 3'd1), 2'd1, 16'h00FE, 16'h0, 16'h0, 4'b1000, 1'b0));

    // Reset state
    #2 resetn = 1'b1;
    repeat (2) @(negedge clock);
    check("rst bus", {16'b0, bus}, 32'h0);
    check("rst flags", {28'b0, flags}, 32'h0);
    check("rst ready", {31'b0, iin_ready}, 32'h0);
    check("rst done", {31'b0, done}, 32'h0);
    resetn = 1'b0;
    @(negedge clock);
    check("ready after release", {31'b0, iin_ready}, 32'h1);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      send(v.ins, 1'b0);
      for (int s = 0; s < int'(v.steps); s++) begin
        @(negedge clock);
        check($sformatf("v%0d bus t%0d", i, s + 1), {16'b0, bus},
              {16'b0, (s == 0) ? v.b0 : (s == 1) ? v.b1 : v.b2});
        check($sformatf("v%0d done early", i), {31'b0, done}, 32'h0);
      end
      @(negedge clock);
      check($sformatf("v%0d done", i), {31'b0, done}, 32'h1);
      check($sformatf("v%0d illegal", i), {31'b0, illegal}, {31'b0, v.ill});
      check($sformatf("v%0d flags", i), {28'b0, flags}, {28'b0, v.fl});
      check($sformatf("v%0d ready", i), {31'b0, iin_ready}, 32'h1);
    end

    // Valid held through an ADD: next instruction accepted only at E4
    send(enc(4'd2, 3'd2, 3'd2), 1'b1);
    iin = mvi(3'd6, 9'h007);
    @(negedge clock);
    check("hs t1 ready", {31'b0, iin_ready}, 32'h0);
    check("hs t1 bus", {16'b0, bus}, 32'hFFFF);
    @(negedge clock);
    check("hs t2 ready", {31'b0, iin_ready}, 32'h0);
    check("hs t2 bus", {16'b0, bus}, 32'hFFFF);
    @(negedge clock);
    check("hs t3 ready", {31'b0, iin_ready}, 32'h0);
    check("hs t3 bus", {16'b0, bus}, 32'hFFFE);
    @(negedge clock);
    check("hs add done", {31'b0, done}, 32'h1);
    check("hs add flags", {28'b0, flags}, 32'b0110);
    check("hs idle bus", {16'b0, bus}, 32'h0);
    @(negedge clock);
    check("hs mvi bus", {16'b0, bus}, 32'h0007);
    check("hs mvi no done", {31'b0, done}, 32'h0);
    iin_valid = 1'b0;
    @(negedge clock);
    check("hs mvi done", {31'b0, done}, 32'h1);

    // Reset during T2 of ADD R1,R2 aborts it
    send(enc(4'd2, 3'd1, 3'd2), 1'b0);
    @(negedge clock);
    check("ab t1 bus", {16'b0, bus}, 32'h00FE);
    @(negedge clock);
    check("ab t2 bus", {16'b0, bus}, 32'hFFFE);
    resetn = 1'b1;
    #1;
    check("ab bus", {16'b0, bus}, 32'h0);
    check("ab flags", {28'b0, flags}, 32'h0);
    check("ab ready", {31'b0, iin_ready}, 32'h0);
    @(negedge clock);
    check("ab no done", {31'b0, done}, 32'h0);
    resetn = 1'b0;
    @(negedge clock);
    check("ab ready after", {31'b0, iin_ready}, 32'h1);
    check("ab no done 2", {31'b0, done}, 32'h0);
    send(enc(4'd0, 3'd1, 3'd1), 1'b0);
    @(negedge clock);
    check("ab r1 bus", {16'b0, bus}, 32'h0);
    @(negedge clock);
    check("ab peek done", {31'b0, done}, 32'h1);

    // Wide configuration
    run32(32'h1FFFFFFD, 1, 32'hFFFFFFFD, 32'h0, 32'h0, 4'b0000);
    run32(32'h0FF00000, 1, 32'hFFFFFFFD, 32'h0, 32'h0, 4'b0000);
    run32(32'h2FF00000, 3, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'hFFFFFFFA, 4'b0110);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
